// File: rtl/rca_64bit_adder.sv
// Registered WIDTH-bit ripple-carry adder with a behavioural reference
// adder running alongside it. Every result is compared against the
// reference and any disagreement is flagged per result and stickily.
module rca_64bit_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             error,
    output logic             error_sticky
);

    // One-bit full adder; returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // ---- Stage p0: combinational ripple chain and reference compare ----
    logic [WIDTH-1:0] s_p0;
    logic [WIDTH:0]   c_p0;
    logic [WIDTH:0]   ref_p0;
    logic             mismatch_p0;

    // Ripple the carry bit by bit from c_in up to the carry out of the MSB.
    always_comb begin
        s_p0    = '0;
        c_p0    = '0;
        c_p0[0] = c_in;
        for (int i = 0; i < WIDTH; i++) begin
            {c_p0[i+1], s_p0[i]} = full_add(a[i], b[i], c_p0[i]);
        end
    end

    // Behavioural reference at WIDTH+1 bits so its carry is captured too.
    always_comb begin
        ref_p0      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        mismatch_p0 = (s_p0 != ref_p0[WIDTH-1:0]) | (c_p0[WIDTH] != ref_p0[WIDTH]);
    end

    // ---- Stage p1: registered result, valid and error flags ----
    logic             vld_p1;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             err_p1;
    logic             sticky_p1;

    // Capture a result on every valid cycle; hold the last result otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sum_p1    <= '0;
            cout_p1   <= 1'b0;
            err_p1    <= 1'b0;
            sticky_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1    <= s_p0;
                cout_p1   <= c_p0[WIDTH];
                err_p1    <= mismatch_p0;
                sticky_p1 <= sticky_p1 | mismatch_p0;
            end
        end
    end

    assign out_valid    = vld_p1;
    assign sum          = sum_p1;
    assign c_out        = cout_p1;
    assign error        = err_p1;
    assign error_sticky = sticky_p1;

endmodule

// File: tb/tb_rca_64bit_adder.sv
// Scoreboard bench for rca_64bit_adder: a driver issues operands and pushes
// the expected result; a negedge monitor pops and compares whatever the DUT
// presents, and also checks hold behaviour on idle cycles.
module tb_rca_64bit_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic [63:0] sum;
    logic        c_out;
    logic        error;
    logic        error_sticky;

    rca_64bit_adder #(.WIDTH(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .c_in(c_in),
        .out_valid(out_valid),
        .sum(sum),
        .c_out(c_out),
        .error(error),
        .error_sticky(error_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] s;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [63:0] last_sum = '0;
    logic        last_c = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Issue one operand set with an explicitly supplied expected result.
    task automatic issue_exp(input logic [63:0] ia, input logic [63:0] ib, input logic ic,
                             input logic [63:0] es, input logic ec);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        c_in = ic;
        e.s = es;
        e.c = ec;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Issue one operand set, expected result from plain 65-bit arithmetic.
    task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic ic);
        logic [64:0] r;
        r = {1'b0, ia} + {1'b0, ib} + {64'd0, ic};
        issue_exp(ia, ib, ic, r[63:0], r[64]);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
    endtask

    // Assert reset between edges, check outputs clear at once, then release.
    task automatic pulse_reset(input int hold_cycles);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_c_out", {63'd0, c_out}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_error_sticky", {63'd0, error_sticky}, 64'd0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
        end
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare against the scoreboard, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                chk("inreset_out_valid", {63'd0, out_valid}, 64'd0);
                chk("inreset_sum", sum, 64'd0);
                last_sum = '0;
                last_c = 1'b0;
            end else begin
                chk("error", {63'd0, error}, 64'd0);
                chk("error_sticky", {63'd0, error_sticky}, 64'd0);
                if (out_valid) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc + 1 != cyc) begin
                        chk("unexpected_out_valid", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sum", sum, e.s);
                        chk("c_out", {63'd0, c_out}, {63'd0, e.c});
                        last_sum = e.s;
                        last_c = e.c;
                    end
                end else begin
                    if (exp_q.size() != 0 && exp_q[0].cyc + 1 <= cyc) begin
                        chk("missing_out_valid", 64'd0, 64'd1);
                        void'(exp_q.pop_front());
                    end
                    chk("hold_sum", sum, last_sum);
                    chk("hold_c_out", {63'd0, c_out}, {63'd0, last_c});
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        rst_n = 1'b0;
        #1;
        chk("init_out_valid", {63'd0, out_valid}, 64'd0);
        chk("init_sum", sum, 64'd0);
        chk("init_c_out", {63'd0, c_out}, 64'd0);
        chk("init_error", {63'd0, error}, 64'd0);
        chk("init_error_sticky", {63'd0, error_sticky}, 64'd0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed vectors with hand-derived results.
        issue_exp(64'hA180C9BFC723279F, 64'hA282AC73ED441906, 1'b0, 64'h44037633B46740A5, 1'b1);
        issue_exp(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        issue_exp(64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h0000000000000000, 1'b0);
        issue_exp(64'h00000005BBBE5A4C, 64'h000000000001579E, 1'b1, 64'h00000005BBBFB1EB, 1'b0);
        issue_exp(64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 1'b1, 64'h0000000000000000, 1'b1);
        issue_exp(64'h000000A8937BC62D, 64'h00000000ABCD385E, 1'b0, 64'h000000A93F48FE8B, 1'b0);
        idle();
        idle();
        idle();

        // Sustained random traffic with a reset pulse in the middle.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) pulse_reset(3);
            issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end
        idle();
        idle();
        idle();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
